memory_responder: RTL and testbench

Word-addressed data-memory responder that serves the load/store request interface driven by the core (`memory_addr`, `memory_rden`, `memory_wren`, `memory_write_val`, `memory_read_val`, `memory_response`). It accepts one request at a time, waits a programmable latency, performs the access on an internal synchronous array, and returns a single-cycle response pulse. It sits on the memory side of that interface and is the core's data memory in simulation and synthesis.

---
 rtl/memory_responder.sv | 98 +++++++++
 tb/tb_memory_responder.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_responder.sv
// Word-addressed data memory behind the core's load/store request interface.
// One request at a time: accept, wait LATENCY edges, access the array, pulse a response.
module memory_responder #(
  parameter int          ADDR_WIDTH = 10,
  parameter int          LATENCY    = 2,
  parameter logic [31:0] ERR_DATA   = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] memory_addr,
  input  logic        memory_rden,
  input  logic        memory_wren,
  input  logic [31:0] memory_write_val,
  output logic [31:0] memory_read_val,
  output logic        memory_response,
  output logic        memory_error,
  output logic        busy
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_reg;
  logic [3:0]  count_reg;
  logic [29:0] addr_reg;
  logic [31:0] wdata_reg;
  logic        is_write_reg;

  logic [31:0] mem_array [0:DEPTH-1];

  logic                  out_of_range;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic                  resp_edge;
  logic                  unused_addr_bits;

  // Byte-offset bits never take part in addressing.
  assign unused_addr_bits = ^memory_addr[1:0];

  assign out_of_range = |addr_reg[29:ADDR_WIDTH];
  assign word_idx     = addr_reg[ADDR_WIDTH-1:0];
  assign resp_edge    = (state_reg == WAIT) && (count_reg == 4'd0);

  // Array has no reset; the write strobe comes from reset-cleared state, so an aborted access never lands.
  always_ff @(posedge clk) begin
    if (resp_edge && is_write_reg && !out_of_range) begin
      mem_array[word_idx] <= wdata_reg;
    end
  end

  // The response always trails acceptance by exactly LATENCY edges, including LATENCY=1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg       <= IDLE;
      count_reg       <= 4'd0;
      addr_reg        <= '0;
      wdata_reg       <= '0;
      is_write_reg    <= 1'b0;
      memory_response <= 1'b0;
      memory_error    <= 1'b0;
      busy            <= 1'b0;
      memory_read_val <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (memory_rden || memory_wren) begin
            addr_reg     <= memory_addr[31:2];
            wdata_reg    <= memory_write_val;
            is_write_reg <= memory_wren;
            count_reg    <= 4'(LATENCY - 1);
            busy         <= 1'b1;
            state_reg    <= WAIT;
          end
        end
        WAIT: begin
          if (count_reg == 4'd0) begin
            state_reg       <= RESP;
            memory_response <= 1'b1;
            memory_error    <= out_of_range;
            if (!is_write_reg) begin
              memory_read_val <= out_of_range ? ERR_DATA : mem_array[word_idx];
            end
          end else begin
            count_reg <= count_reg - 4'd1;
          end
        end
        RESP: begin
          memory_response <= 1'b0;
          memory_error    <= 1'b0;
          busy            <= 1'b0;
          state_reg       <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_responder.sv
// Randomised and directed checks of memory_responder against an associative-array memory model.
module tb_memory_responder;

  localparam int          AW  = 10;
  localparam int          LAT = 2;
  localparam logic [31:0] ERR = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] memory_addr = '0;
  logic        memory_rden = 1'b0;
  logic        memory_wren = 1'b0;
  logic [31:0] memory_write_val = '0;
  logic [31:0] memory_read_val;
  logic        memory_response;
  logic        memory_error;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: word-indexed contents plus the last completed read value.
  logic [31:0] ref_mem [int unsigned];
  logic [31:0] exp_rdval = '0;
  logic [31:0] written_q [$];

  memory_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT), .ERR_DATA(ERR)) dut (
    .clk(clk), .reset(reset), .memory_addr(memory_addr), .memory_rden(memory_rden),
    .memory_wren(memory_wren), .memory_write_val(memory_write_val),
    .memory_read_val(memory_read_val), .memory_response(memory_response),
    .memory_error(memory_error), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  function automatic logic is_oor(input logic [31:0] a);
    return (a >> (AW + 2)) != 0;
  endfunction

  function automatic int unsigned word_of(input logic [31:0] a);
    return (a >> 2) % (1 << AW);
  endfunction

  // Model: computes error flag and the read value that should be visible during the response.
  task automatic model_apply(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                             output logic exp_err, output logic [31:0] exp_val);
    exp_err = is_oor(a);
    if (wr) begin
      if (!is_oor(a)) ref_mem[word_of(a)] = d;
    end else if (rd) begin
      if (is_oor(a)) exp_rdval = ERR;
      else if (ref_mem.exists(word_of(a))) exp_rdval = ref_mem[word_of(a)];
      else exp_rdval = 'x;
    end
    exp_val = exp_rdval;
  endtask

  // Drives one request from a negedge, waits (bounded) for its response, then drops it.
  task automatic issue(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                       output int lat, output logic [31:0] rv, output logic err,
                       output logic busy_ok, output logic resp_after, output logic timed_out);
    logic done;
    memory_rden = rd; memory_wren = wr; memory_addr = a; memory_write_val = d;
    lat = 0; busy_ok = 1'b1; timed_out = 1'b0; rv = 'x; err = 1'bx; done = 1'b0;
    @(posedge clk);
    while (!done) begin
      @(negedge clk);
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (memory_response === 1'b1) begin
        rv = memory_read_val; err = memory_error; done = 1'b1;
      end else if (lat >= 40) begin
        timed_out = 1'b1; done = 1'b1;
      end else begin
        @(posedge clk);
        lat++;
      end
    end
    memory_rden = 1'b0; memory_wren = 1'b0;
    @(negedge clk);
    resp_after = memory_response | memory_error;
    $display("txn rd=%0b wr=%0b addr=%h wdata=%h -> rdata=%h err=%0b lat=%0d", rd, wr, a, d, rv, err, lat);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({memory_response, memory_error, busy, memory_read_val} !== 35'd0) begin
      miscompares++;
      $display("FAIL reset_hold: got %h expected 0", {memory_response, memory_error, busy, memory_read_val});
    end
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      vectors++;
      if ({memory_response, memory_error, busy, memory_read_val} !== 35'd0) begin
        miscompares++;
        $display("FAIL idle_after_reset cycle %0d: got %h expected 0", i,
                 {memory_response, memory_error, busy, memory_read_val});
      end
    end
    exp_rdval = '0;
  endtask

  task automatic test_write_read();
    int lat; logic [31:0] rv, ev; logic err, ee, bok, ra, to;
    logic [31:0] addrs [3];
    addrs[0] = 32'h10; addrs[1] = 32'h10; addrs[2] = 32'h13;
    for (int i = 0; i < 3; i++) begin
      logic wr;
      wr = (i == 0);
      issue(!wr, wr, addrs[i], 32'hCAFEF00D, lat, rv, err, bok, ra, to);
      model_apply(!wr, wr, addrs[i], 32'hCAFEF00D, ee, ev);
      vectors++;
      if ({to, 4'(lat), err, ra, bok} !== {1'b0, 4'(LAT), ee, 1'b0, 1'b1}) begin
        miscompares++;
        $display("FAIL wr_rd_handshake %0d: got to/lat/err/next/busy=%h expected %h", i,
                 {to, 4'(lat), err, ra, bok}, {1'b0, 4'(LAT), ee, 1'b0, 1'b1});
      end
      if (!wr) begin
        vectors++;
        if (rv !== 32'hCAFEF00D) begin
          miscompares++;
          $display("FAIL wr_rd_data addr %h: got %h expected %h", addrs[i], rv, 32'hCAFEF00D);
        end
      end
    end
    written_q.push_back(32'h10);
  endtask

  task automatic test_out_of_range();
    int lat; logic [31:0] rv, ev; logic err, ee, bok, ra, to;
    logic [31:0] a [4]; logic [31:0] d [4]; logic w [4];
    a[0] = 32'h0;    d[0] = 32'h600DCAFE; w[0] = 1'b1;
    a[1] = 32'h1000; d[1] = 32'h12345678; w[1] = 1'b1;
    a[2] = 32'h1000; d[2] = 32'h0;        w[2] = 1'b0;
    a[3] = 32'h0;    d[3] = 32'h0;        w[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      issue(!w[i], w[i], a[i], d[i], lat, rv, err, bok, ra, to);
      model_apply(!w[i], w[i], a[i], d[i], ee, ev);
      vectors++;
      if ({to, 4'(lat), err, ra} !== {1'b0, 4'(LAT), ee, 1'b0}) begin
        miscompares++;
        $display("FAIL oor_status %0d addr %h: got to/lat/err/next=%h expected %h", i, a[i],
                 {to, 4'(lat), err, ra}, {1'b0, 4'(LAT), ee, 1'b0});
      end
      vectors++;
      if (rv !== ev) begin
        miscompares++;
        $display("FAIL oor_data %0d addr %h: got %h expected %h", i, a[i], rv, ev);
      end
    end
    written_q.push_back(32'h0);
  endtask

  task automatic test_held_request();
    int lat; logic [31:0] rv, ev; logic err, ee, bok, ra, to;
    int idx_q [$]; logic prev; int exp_cnt;
    issue(1'b0, 1'b1, 32'h20, 32'h2020ABCD, lat, rv, err, bok, ra, to);
    model_apply(1'b0, 1'b1, 32'h20, 32'h2020ABCD, ee, ev);
    written_q.push_back(32'h20);
    memory_rden = 1'b1; memory_addr = 32'h20;
    prev = 1'b0;
    for (int n = 1; n <= 24; n++) begin
      @(negedge clk);
      if (memory_response === 1'b1) begin
        idx_q.push_back(n);
        vectors++;
        if (prev) begin
          miscompares++;
          $display("FAIL held_consecutive at cycle %0d: got 2 adjacent pulses expected 1", n);
        end
        vectors++;
        if (memory_read_val !== 32'h2020ABCD) begin
          miscompares++;
          $display("FAIL held_data cycle %0d: got %h expected %h", n, memory_read_val, 32'h2020ABCD);
        end
      end
      prev = (memory_response === 1'b1);
    end
    memory_rden = 1'b0;
    exp_cnt = (24 - (LAT + 1)) / (LAT + 2) + 1;
    vectors++;
    if (idx_q.size() !== exp_cnt) begin
      miscompares++;
      $display("FAIL held_count: got %0d expected %0d", idx_q.size(), exp_cnt);
    end
    vectors++;
    if (idx_q.size() == 0 || idx_q[0] !== LAT + 1) begin
      miscompares++;
      $display("FAIL held_first: got %0d expected %0d", (idx_q.size() == 0) ? -1 : idx_q[0], LAT + 1);
    end
    for (int i = 1; i < idx_q.size(); i++) begin
      vectors++;
      if (idx_q[i] - idx_q[i-1] !== LAT + 2) begin
        miscompares++;
        $display("FAIL held_spacing %0d: got %0d expected %0d", i, idx_q[i] - idx_q[i-1], LAT + 2);
      end
    end
    repeat (LAT + 3) @(negedge clk);
    vectors++;
    if ({busy, memory_response} !== 2'b00) begin
      miscompares++;
      $display("FAIL held_drain: got busy/resp=%b expected 00", {busy, memory_response});
    end
    exp_rdval = 32'h2020ABCD;
  endtask

  task automatic test_simultaneous();
    int lat; logic [31:0] rv, ev; logic err, ee, bok, ra, to;
    issue(1'b1, 1'b1, 32'h30, 32'hA5A5A5A5, lat, rv, err, bok, ra, to);
    model_apply(1'b1, 1'b1, 32'h30, 32'hA5A5A5A5, ee, ev);
    vectors++;
    if ({to, 4'(lat), err, rv} !== {1'b0, 4'(LAT), 1'b0, ev}) begin
      miscompares++;
      $display("FAIL rdwr_keeps_rdval: got to/lat/err/rdata=%h expected %h",
               {to, 4'(lat), err, rv}, {1'b0, 4'(LAT), 1'b0, ev});
    end
    issue(1'b1, 1'b0, 32'h30, 32'h0, lat, rv, err, bok, ra, to);
    model_apply(1'b1, 1'b0, 32'h30, 32'h0, ee, ev);
    vectors++;
    if (rv !== 32'hA5A5A5A5) begin
      miscompares++;
      $display("FAIL rdwr_readback: got %h expected %h", rv, 32'hA5A5A5A5);
    end
    written_q.push_back(32'h30);
  endtask

  task automatic test_reset_mid_op();
    int lat; logic [31:0] rv, ev; logic err, ee, bok, ra, to; int seen;
    issue(1'b0, 1'b1, 32'h40, 32'h0BADF00D, lat, rv, err, bok, ra, to);
    model_apply(1'b0, 1'b1, 32'h40, 32'h0BADF00D, ee, ev);
    memory_wren = 1'b1; memory_addr = 32'h40; memory_write_val = 32'h11111111;
    @(posedge clk);
    @(negedge clk);
    memory_wren = 1'b0;
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL midop_busy_before: got %b expected 1", busy);
    end
    reset = 1'b0;
    #1;
    vectors++;
    if ({busy, memory_response, memory_read_val} !== 34'd0) begin
      miscompares++;
      $display("FAIL midop_reset_outputs: got %h expected 0", {busy, memory_response, memory_read_val});
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    exp_rdval = '0;
    seen = 0;
    for (int i = 0; i < LAT + 4; i++) begin
      @(negedge clk);
      if (memory_response === 1'b1 || busy === 1'b1) seen++;
    end
    vectors++;
    if (seen !== 0) begin
      miscompares++;
      $display("FAIL midop_no_response: got %0d active cycles expected 0", seen);
    end
    issue(1'b1, 1'b0, 32'h40, 32'h0, lat, rv, err, bok, ra, to);
    model_apply(1'b1, 1'b0, 32'h40, 32'h0, ee, ev);
    vectors++;
    if ({to, rv} !== {1'b0, 32'h0BADF00D}) begin
      miscompares++;
      $display("FAIL midop_readback: got to/rdata=%h expected %h", {to, rv}, {1'b0, 32'h0BADF00D});
    end
    written_q.push_back(32'h40);
  endtask

  task automatic test_random();
    int lat; logic [31:0] rv, ev; logic err, ee, bok, ra, to;
    for (int i = 0; i < 40; i++) begin
      logic rd, wr; logic [31:0] a, d;
      d = $urandom();
      wr = ($urandom_range(0, 1) == 1);
      rd = !wr || ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 5) == 0) begin
        a = $urandom();
        if (a < 32'h1000) a = a | 32'h1000;
      end else if (wr) begin
        a = $urandom_range(0, 32'hFFF);
      end else begin
        a = written_q[$urandom_range(0, written_q.size() - 1)] ^ 32'($urandom_range(0, 3));
      end
      if (wr && !is_oor(a)) written_q.push_back(a);
      issue(rd, wr, a, d, lat, rv, err, bok, ra, to);
      model_apply(rd, wr, a, d, ee, ev);
      vectors++;
      if ({to, 4'(lat), err, ra, bok} !== {1'b0, 4'(LAT), ee, 1'b0, 1'b1}) begin
        miscompares++;
        $display("FAIL rand_status %0d addr %h: got to/lat/err/next/busy=%h expected %h", i, a,
                 {to, 4'(lat), err, ra, bok}, {1'b0, 4'(LAT), ee, 1'b0, 1'b1});
      end
      vectors++;
      if (rv !== ev) begin
        miscompares++;
        $display("FAIL rand_data %0d addr %h: got %h expected %h", i, a, rv, ev);
      end
    end
  endtask

  initial begin
    test_reset();
    @(negedge clk);
    test_write_read();
    test_out_of_range();
    test_held_request();
    test_simultaneous();
    test_reset_mid_op();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
